// File: rtl/tomasulo_pkg.sv
// Shared widths, source numbering and the CDB broadcast record for the
// writeback stage of the Tomasulo issue path.
package tomasulo_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;
    localparam int NSRC   = 7;
    localparam int SRC_W  = 3;

    // Result source numbering: three adders, three multipliers, one loader.
    localparam logic [SRC_W-1:0] SRC_ADD0 = 3'd0;
    localparam logic [SRC_W-1:0] SRC_ADD1 = 3'd1;
    localparam logic [SRC_W-1:0] SRC_ADD2 = 3'd2;
    localparam logic [SRC_W-1:0] SRC_MUL0 = 3'd3;
    localparam logic [SRC_W-1:0] SRC_MUL1 = 3'd4;
    localparam logic [SRC_W-1:0] SRC_MUL2 = 3'd5;
    localparam logic [SRC_W-1:0] SRC_LOAD = 3'd6;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr_i
// (wrapping at NSRC) wins. Grant is one-hot, or zero when nobody requests.
module rr_arbiter
    import tomasulo_pkg::*;
(
    input  logic [NSRC-1:0]  req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [NSRC-1:0]  grant_o,
    output logic [SRC_W-1:0] winner_o
);

    int                idx;
    logic [SRC_W-1:0]  sel;
    logic              found;

    // Scan the requesters starting at the pointer and stop at the first hit.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            sel = SRC_W'(idx);
            if (!found && req_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                winner_o     = sel;
            end
        end
    end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Writeback arbiter: one holding slot per execution unit, one registered
// CDB broadcast per cycle chosen round-robin. A slot being broadcast may be
// refilled on the same edge, so a unit producing every cycle never stalls.
module cdb_writeback_arbiter
    import tomasulo_pkg::*;
(
    input  logic                   clk2,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [NSRC*TAG_W-1:0]  src_tag,
    output logic [NSRC-1:0]        src_ready,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [DATA_W-1:0]      cdb_data,
    output logic [SRC_W-1:0]       cdb_src,
    output logic [2:0]             pending_cnt
);

    logic [NSRC-1:0]   full_q, full_d;
    logic [DATA_W-1:0] data_q [NSRC];
    logic [TAG_W-1:0]  tag_q  [NSRC];
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    cdb_t              cdb_q, cdb_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [NSRC-1:0]   grant;
    logic [SRC_W-1:0]  winner;
    logic [NSRC-1:0]   accept;
    logic [2:0]        pending;

    rr_arbiter u_rr_arbiter (
        .req_i    (full_q),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // Accept handshake and next-state for slots, pointer and broadcast.
    // Flush wins over both capture and grant; the pointer survives a flush.
    always_comb begin
        src_ready = flush ? '0 : (~full_q | grant);
        accept    = src_valid & src_ready;
        full_d    = flush ? '0 : ((full_q & ~grant) | accept);
        cdb_d     = cdb_q;
        cdb_src_d = cdb_src_q;
        rr_ptr_d  = rr_ptr_q;
        if (flush) begin
            cdb_d.valid = 1'b0;
        end else if (|grant) begin
            cdb_d.valid = 1'b1;
            cdb_d.tag   = tag_q[winner];
            cdb_d.data  = data_q[winner];
            cdb_src_d   = winner;
            rr_ptr_d    = (winner == SRC_LOAD) ? SRC_ADD0 : winner + 3'd1;
        end else begin
            cdb_d.valid = 1'b0;
        end
    end

    // Occupied-slot count; full_q already reflects the most recent edge.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NSRC; i++) begin
            pending = pending + {2'b00, full_q[i]};
        end
    end

    // Control state: slot occupancy, round-robin pointer, CDB registers.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            rr_ptr_q  <= '0;
            cdb_q     <= '0;
            cdb_src_q <= '0;
        end else begin
            full_q    <= full_d;
            rr_ptr_q  <= rr_ptr_d;
            cdb_q     <= cdb_d;
            cdb_src_q <= cdb_src_d;
        end
    end

    // Slot payload capture on each accepted handshake.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (accept[i]) begin
                    data_q[i] <= src_data[i*DATA_W +: DATA_W];
                    tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    end

    assign cdb_valid   = cdb_q.valid;
    assign cdb_tag     = cdb_q.tag;
    assign cdb_data    = cdb_q.data;
    assign cdb_src     = cdb_src_q;
    assign pending_cnt = pending;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for the CDB writeback arbiter: directed scenarios plus a random run,
// all tracked by a slot/queue-level reference model.
module tb_cdb_writeback_arbiter;

    logic         clk2 = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [6:0]   src_valid = '0;
    logic [223:0] src_data = '0;
    logic [20:0]  src_tag = '0;
    logic [6:0]   src_ready;
    logic         cdb_valid;
    logic [2:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [2:0]   cdb_src;
    logic [2:0]   pending_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_full [7];
    logic [31:0] m_data [7];
    logic [2:0]  m_tag  [7];
    int          m_ptr;
    logic        m_valid;
    logic [2:0]  m_ctag;
    logic [31:0] m_cdata;
    logic [2:0]  m_csrc;
    logic [6:0]  m_ready;
    logic [6:0]  rdy_seen;

    cdb_writeback_arbiter dut (
        .clk2        (clk2),
        .rst_n       (rst_n),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_tag     (src_tag),
        .src_ready   (src_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_src     (cdb_src),
        .pending_cnt (pending_cnt)
    );

    always #5 clk2 = ~clk2;

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 7; i++) n += m_full[i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_full[i] = 0; m_data[i] = '0; m_tag[i] = '0;
        end
        m_ptr = 0; m_valid = 0; m_ctag = '0; m_cdata = '0; m_csrc = '0; m_ready = '1;
    endtask

    // One clock of behaviour: oldest-pointer-first scan, broadcast, then capture.
    task automatic model_step();
        int w = -1;
        if (!flush) begin
            for (int k = 0; k < 7; k++) begin
                int j = (m_ptr + k) % 7;
                if (w < 0 && m_full[j]) w = j;
            end
        end
        for (int i = 0; i < 7; i++) m_ready[i] = !flush && (!m_full[i] || i == w);
        if (flush) begin
            for (int i = 0; i < 7; i++) m_full[i] = 0;
            m_valid = 0;
        end else begin
            if (w >= 0) begin
                m_valid = 1; m_ctag = m_tag[w]; m_cdata = m_data[w];
                m_csrc = 3'(w); m_ptr = (w + 1) % 7; m_full[w] = 0;
            end else begin
                m_valid = 0;
            end
            for (int i = 0; i < 7; i++) begin
                if (src_valid[i] && m_ready[i]) begin
                    m_full[i] = 1;
                    m_data[i] = src_data[i*32 +: 32];
                    m_tag[i]  = src_tag[i*3 +: 3];
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        rdy_seen = src_ready;
        model_step();
        @(posedge clk2);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] d, input logic [2:0] t);
        src_data[i*32 +: 32] = d;
        src_tag[i*3 +: 3]    = t;
    endtask

    task automatic do_reset();
        src_valid = '0; flush = 1'b0; rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", cdb_valid); end
        checks++; if (cdb_tag !== 3'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", cdb_tag); end
        checks++; if (cdb_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", cdb_data); end
        checks++; if (cdb_src !== 3'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", cdb_src); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        #4;
        rst_n = 1'b1;
        #1;
        checks++; if (src_ready !== 7'h7f) begin failures++; $display("FAIL reset_ready got=%0h exp=7f", src_ready); end
    endtask

    task automatic test_single();
        do_reset();
        set_src(0, 32'h5, 3'd3);
        src_valid = 7'b1;
        tick();
        src_valid = '0;
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL single_pend1 got=%0d exp=1", pending_cnt); end
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%0b exp=0", cdb_valid); end
        tick();
        checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", cdb_valid); end
        checks++; if (cdb_tag !== 3'd3) begin failures++; $display("FAIL single_tag got=%0d exp=3", cdb_tag); end
        checks++; if (cdb_data !== 32'h5) begin failures++; $display("FAIL single_data got=%0h exp=5", cdb_data); end
        checks++; if (cdb_src !== 3'd0) begin failures++; $display("FAIL single_src got=%0d exp=0", cdb_src); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL single_pend0 got=%0d exp=0", pending_cnt); end
        tick();
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", cdb_valid); end
    endtask

    task automatic test_all_sources();
        do_reset();
        for (int i = 0; i < 7; i++) set_src(i, 32'h10 + i, 3'(i));
        src_valid = 7'h7f;
        tick();
        src_valid = '0;
        checks++; if (pending_cnt !== 3'd7) begin failures++; $display("FAIL all_pend7 got=%0d exp=7", pending_cnt); end
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== 3'(k) || cdb_tag !== 3'(k) || cdb_data !== 32'h10 + k
                || pending_cnt !== 3'(6 - k)) begin
                failures++;
                $display("FAIL all_bcast%0d got=v%0b s%0d t%0d d%0h p%0d exp=v1 s%0d t%0d d%0h p%0d",
                         k, cdb_valid, cdb_src, cdb_tag, cdb_data, pending_cnt, k, k, 32'h10 + k, 6 - k);
            end
        end
        checks++; if (src_ready !== 7'h7f) begin failures++; $display("FAIL all_ready got=%0h exp=7f", src_ready); end
    endtask

    task automatic test_rr_fairness();
        bit found = 0;
        set_src(4, 32'h44, 3'd4);
        src_valid = 7'b001_0000;
        tick();
        src_valid = '0;
        tick();
        checks++; if (cdb_src !== 3'd4) begin failures++; $display("FAIL rr_setup got=%0d exp=4", cdb_src); end
        set_src(1, 32'h11, 3'd1);
        set_src(6, 32'h66, 3'd6);
        src_valid = 7'b100_0010;
        tick();
        src_valid = '0;
        tick();
        checks++; if (cdb_src !== 3'd6) begin failures++; $display("FAIL rr_first got=%0d exp=6", cdb_src); end
        tick();
        checks++; if (cdb_src !== 3'd1) begin failures++; $display("FAIL rr_second got=%0d exp=1", cdb_src); end
        set_src(2, 32'h22, 3'd2);
        set_src(5, 32'h55, 3'd5);
        src_valid = 7'b010_0100;
        tick();
        src_valid = 7'b000_0100;
        for (int c = 0; c < 7 && !found; c++) begin
            tick();
            if (cdb_valid === 1'b1 && cdb_src === 3'd5) found = 1;
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL rr_starve got=notseen exp=src5_within7"); end
        src_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        for (int v = 1; v <= 3; v++) begin
            set_src(3, 32'(v), 3'(v));
            src_valid = 7'b000_1000;
            tick();
            checks++; if (rdy_seen[3] !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%0b exp=1", v, rdy_seen[3]); end
            if (v >= 2) begin
                checks++;
                if (cdb_valid !== 1'b1 || cdb_data !== 32'(v - 1) || cdb_src !== 3'd3) begin
                    failures++;
                    $display("FAIL b2b_data%0d got=v%0b d%0h s%0d exp=v1 d%0h s3", v, cdb_valid, cdb_data, cdb_src, v - 1);
                end
            end
        end
        src_valid = '0;
        tick();
        checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'd3) begin failures++; $display("FAIL b2b_last got=v%0b d%0h exp=v1 d3", cdb_valid, cdb_data); end
    endtask

    task automatic test_flush();
        set_src(0, 32'hA0, 3'd5);
        set_src(4, 32'hA4, 3'd6);
        set_src(6, 32'hA6, 3'd7);
        src_valid = 7'b101_0001;
        tick();
        checks++; if (pending_cnt !== 3'd3) begin failures++; $display("FAIL flush_fill got=%0d exp=3", pending_cnt); end
        flush = 1'b1;
        src_valid = 7'h7f;
        tick();
        flush = 1'b0;
        src_valid = '0;
        checks++; if (rdy_seen !== 7'h00) begin failures++; $display("FAIL flush_ready got=%0h exp=0", rdy_seen); end
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", cdb_valid); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL flush_pend got=%0d exp=0", pending_cnt); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_stale%0d got=%0b exp=0", c, cdb_valid); end
        end
    endtask

    task automatic test_async_reset();
        set_src(1, 32'hB1, 3'd1);
        set_src(2, 32'hB2, 3'd2);
        set_src(5, 32'hB5, 3'd5);
        set_src(6, 32'hB6, 3'd6);
        src_valid = 7'b110_0110;
        tick();
        src_valid = '0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 3'd0 || cdb_data !== 32'd0 || cdb_src !== 3'd0 || pending_cnt !== 3'd0) begin
            failures++;
            $display("FAIL async_zero got=v%0b t%0d d%0h s%0d p%0d exp=all0", cdb_valid, cdb_tag, cdb_data, cdb_src, pending_cnt);
        end
        #2;
        rst_n = 1'b1;
        set_src(4, 32'hCAFE, 3'd6);
        src_valid = 7'b001_0000;
        tick();
        src_valid = '0;
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd6 || cdb_data !== 32'hCAFE || cdb_src !== 3'd4) begin
            failures++;
            $display("FAIL async_after got=v%0b t%0d d%0h s%0d exp=v1 t6 dcafe s4", cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            src_valid = 7'($urandom);
            for (int i = 0; i < 7; i++) set_src(i, $urandom, 3'($urandom_range(0, 7)));
            flush = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (rdy_seen !== m_ready || cdb_valid !== m_valid || cdb_tag !== m_ctag || cdb_data !== m_cdata
                || cdb_src !== m_csrc || pending_cnt !== 3'(m_count())) begin
                failures++;
                $display("FAIL rand%0d got=r%0h v%0b t%0d d%0h s%0d p%0d exp=r%0h v%0b t%0d d%0h s%0d p%0d",
                         n, rdy_seen, cdb_valid, cdb_tag, cdb_data, cdb_src, pending_cnt,
                         m_ready, m_valid, m_ctag, m_cdata, m_csrc, m_count());
            end
        end
        flush = 1'b0;
        src_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_sources();
        test_rr_fairness();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
- Writeback end of the issue path. Collects finished results from the three adder units, three multiplier units and the load unit.
- Holds each result in a per-source holding slot, then broadcasts one result per cycle on the common data bus (CDB) as {ROB tag, data}.
- Reservation stations wake up on the broadcast by matching the tag. The ROB marks the entry done.
- Per-source ready tells the execution unit that its result has been taken, so the unit's exe-busy flag can clear.

Parameters:
- DATA_W, 32, result data width
- TAG_W, 3, ROB index width (matches dispatch ROB index)
- NSRC, 7, number of result sources; index 0-2 = adders, 3-5 = multipliers, 6 = loader

Ports:
- clk2  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all pending results (mispredict/exception)
- src_valid  in  NSRC  per-source result valid
- src_data  in  NSRC*DATA_W  per-source result, source i at [i*DATA_W +: DATA_W]
- src_tag  in  NSRC*TAG_W  per-source ROB index
- src_ready  out  NSRC  per-source accept; transfer occurs when src_valid[i] & src_ready[i]
- cdb_valid  out  1  broadcast valid, registered
- cdb_tag  out  TAG_W  broadcast ROB index, registered
- cdb_data  out  DATA_W  broadcast data, registered
- cdb_src  out  3  index of the source being broadcast (debug/ROB cross-check)
- pending_cnt  out  3  number of occupied holding slots

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - All slots empty; rr_ptr = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0, pending_cnt = 0.
  - src_ready = all ones once reset deasserts.
  - A reset mid-operation discards all held results with no broadcast.
- **Slot per source:** full flag, data, tag.
  - src_ready[i] = ~full[i] | grant[i], combinational, so a slot being broadcast this cycle can be refilled on the same edge.
- **Capture:** on a rising edge with src_valid[i] & src_ready[i], slot i loads src_data/src_tag and full[i] = 1.
- **Arbitration:**
  - Each cycle, round-robin over full[] starting at rr_ptr picks one winner; grant is one-hot or zero.
  - On the edge, the winner's slot goes to the cdb_* registers with cdb_valid = 1; full[winner] clears unless refilled the same edge.
  - rr_ptr = (winner + 1) mod NSRC, wrapping from 6 to 0. rr_ptr does not change when there is no winner.
- **Idle:** no full slot means cdb_valid = 0 next cycle; cdb_tag/cdb_data hold their last values.
- **Latency:** a result accepted at edge N is broadcast at the earliest after edge N+1, so cdb_valid is high in cycle N+1. Worst-case wait is NSRC-1 extra cycles, giving starvation-free service.
- **Bypass:** there is no bypass; an incoming result never goes straight to the CDB on its accept edge.
- **Simultaneous events:**
  - All 7 valid in the same cycle: all captured, then broadcast in 7 consecutive cycles in RR order.
  - Refill of the granted slot on the same edge: the new value is held and the old value is broadcast.
- **Flush** (synchronous, has priority over capture and grant):
  - All full cleared; cdb_valid = 0 next cycle; src_ready forced to 0 during the flush cycle.
  - rr_ptr is kept.
- **pending_cnt:** popcount of full[] after the edge, range 0..7.
- **Tag width:** tags pass unmodified. No arithmetic on data.

Decomposition:
- Shared package tomasulo_pkg holds:
  - DATA_W, TAG_W, NSRC
  - source index constants SRC_ADD0..SRC_ADD2, SRC_MUL0..SRC_MUL2, SRC_LOAD
  - a cdb_t struct {valid, tag, data}
- One sub-module, rr_arbiter: inputs req[NSRC] and ptr; outputs grant one-hot and winner index. It is purely combinational.

Test Plan:
- **Single result:** reset, then src_valid[0] with data 0x0000_0005, tag 3 for 1 cycle → next cycle cdb_valid = 1, cdb_tag = 3, cdb_data = 5, cdb_src = 0. cdb_valid = 0 the cycle after. pending_cnt goes 1 → 0.
- **All sources at once:** all 7 sources valid in one cycle, data = 0x10+i, tag = i → 7 consecutive broadcasts with cdb_src 0,1,...,6. pending_cnt goes 7,6,...,0, and src_ready is all ones afterwards.
- **Round-robin fairness:**
  - Setup: rr_ptr = 5 after the previous grant of 4; sources 1 and 6 full.
  - Required order: 6 then 1.
  - Check: with source 2 held continuously valid, source 5 is broadcast within ≤ 7 cycles.
- **Back-to-back refill:** source 3 valid every cycle with incrementing data 1,2,3 → each accepted without a stall; CDB shows 1,2,3 on consecutive cycles; src_ready[3] stays 1.
- **Flush:** fill slots 0, 4 and 6, then assert flush → next cycle cdb_valid = 0 and pending_cnt = 0; src_ready = 0 in the flush cycle; no stale tag is broadcast afterwards.
- **Async reset:** assert rst_n = 0 mid-cycle while 3 slots are full → outputs go to zero immediately, without a clock edge; after release, the first new result is broadcast with the correct tag.
